// File: rtl/usr_ctrl_pkg.sv
// Shared types for the universal-shift-register serdes controller: FSM states and
// the {s1,s0} mode encoding of the shift register.
package usr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // dir=1 shifts left (MSB leaves first), dir=0 shifts right (LSB leaves first)
  function automatic logic [1:0] shift_mode(input logic dir);
    return dir ? MODE_SHL : MODE_SHR;
  endfunction

endpackage

// File: rtl/usr_datapath.sv
// Four-mode universal shift register (hold / shift-right / shift-left / parallel load)
// with synchronous active-high reset.
module usr_datapath
  import usr_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 msb_in,
  input  logic                 lsb_in,
  output logic [WORD_SIZE-1:0] q
);

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      unique case (mode)
        MODE_HOLD: q <= q;
        MODE_SHR:  q <= {msb_in, q[WORD_SIZE-1:1]};
        MODE_SHL:  q <= {q[WORD_SIZE-2:0], lsb_in};
        MODE_LOAD: q <= data_in;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/usr_serdes_ctrl.sv
// Word serializer/deserializer sequencer driving a universal shift register.
// Optional even-parity cycle enabled by defining USR_SERDES_PARITY_EN.
module usr_serdes_ctrl
  import usr_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_rx,
  input  logic                 cmd_dir,
  input  logic [WORD_SIZE-1:0] cmd_data,
  input  logic                 ser_in,
  output logic                 ser_out,
  output logic                 ser_valid,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_err,
  output logic [1:0]           mode
);

  localparam int CNT_W = $clog2(WORD_SIZE + 2);
`ifdef USR_SERDES_PARITY_EN
  localparam int PAR_CYCLES = 1;
`else
  localparam int PAR_CYCLES = 0;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_SIZE + PAR_CYCLES - 1);

  state_t                 state, state_nx;
  logic [CNT_W-1:0]       cnt;
  logic                   rx_q, dir_q;
  logic [WORD_SIZE-1:0]   data_q;
  logic [WORD_SIZE-1:0]   reg_q;
  logic [WORD_SIZE-1:0]   data_in;
  logic                   msb_in, lsb_in;
  logic                   accept;
  logic                   par_cyc;
  logic                   err_q;

  assign accept = cmd_valid && cmd_ready;

`ifdef USR_SERDES_PARITY_EN
  // Final SHIFT cycle carries the parity bit; the register holds through it.
  assign par_cyc = (state == ST_SHIFT) && (cnt == CNT_W'(WORD_SIZE));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == ST_LOAD) begin
      err_q <= 1'b0;
    end else if (par_cyc && rx_q) begin
      err_q <= ser_in ^ (^reg_q);
    end
  end
`else
  assign par_cyc = 1'b0;
  assign err_q   = 1'b0;
`endif

  usr_datapath #(.WORD_SIZE(WORD_SIZE)) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .data_in (data_in),
    .msb_in  (msb_in),
    .lsb_in  (lsb_in),
    .q       (reg_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Latched command and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      rx_q   <= 1'b0;
      dir_q  <= 1'b0;
      data_q <= '0;
    end else begin
      if (accept) begin
        rx_q   <= cmd_rx;
        dir_q  <= cmd_dir;
        data_q <= cmd_data;
      end
      if (state == ST_LOAD)       cnt <= '0;
      else if (state == ST_SHIFT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nx = ST_LOAD;
      ST_LOAD:  state_nx = ST_SHIFT;
      ST_SHIFT: if (cnt == LAST_CNT) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    mode      = MODE_HOLD;
    data_in   = '0;
    msb_in    = 1'b0;
    lsb_in    = 1'b0;
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    cmd_ready = (state == ST_IDLE) && !rst;
    unique case (state)
      ST_LOAD: begin
        mode    = MODE_LOAD;
        data_in = rx_q ? '0 : data_q;
      end
      ST_SHIFT: begin
        ser_valid = 1'b1;
        if (par_cyc) begin
          mode    = MODE_HOLD;
          ser_out = !rx_q && (^data_q);
        end else begin
          mode = shift_mode(dir_q);
          if (rx_q) begin
            msb_in = ser_in;
            lsb_in = ser_in;
          end else begin
            ser_out = dir_q ? reg_q[WORD_SIZE-1] : reg_q[0];
          end
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        rsp_data  = reg_q;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usr_serdes_ctrl.sv
// Scoreboard bench for usr_serdes_ctrl (WORD_SIZE=4): directed then random TX/RX
// transfers against a word-level reference model; honours USR_SERDES_PARITY_EN.
module tb_usr_serdes_ctrl;
  import usr_ctrl_pkg::*;

  localparam int W = 4;
`ifdef USR_SERDES_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0, cmd_rx = 1'b0, cmd_dir = 1'b0, ser_in = 1'b0;
  logic [W-1:0] cmd_data = '0;
  logic         cmd_ready, ser_out, ser_valid, rsp_valid, rsp_err;
  logic [W-1:0] rsp_data;
  logic [1:0]   mode;

  usr_serdes_ctrl #(.WORD_SIZE(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rx    (cmd_rx),
    .cmd_dir   (cmd_dir),
    .cmd_data  (cmd_data),
    .ser_in    (ser_in),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mode      (mode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       b;
    logic       chk;
    logic [1:0] mode;
  } ser_t;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           cyc;
  } rsp_t;

  ser_t ser_q[$];
  rsp_t rsp_q[$];
  int   load_q[$];
  logic rxbit_q[$];
  logic mon_en = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: called at the negedge before the accepting edge.
  task automatic issue(input logic rx, input logic dir, input logic [W-1:0] data,
                       input logic [W-1:0] bits, input logic pbad);
    int           e;
    logic [W-1:0] word;
    ser_t         s;
    rsp_t         r;
    cmd_valid = 1'b1;
    cmd_rx    = rx;
    cmd_dir   = dir;
    cmd_data  = data;
    e = cyc + 1;
    load_q.push_back(e);
    word = '0;
    for (int i = 0; i < W; i++) begin
      s.mode = dir ? MODE_SHL : MODE_SHR;
      if (rx) begin
        s.b = 1'b0; s.chk = 1'b0;
        rxbit_q.push_back(bits[i]);
        if (dir) word[W-1-i] = bits[i];
        else     word[i]     = bits[i];
      end else begin
        s.b = dir ? data[W-1-i] : data[i];
        s.chk = 1'b1;
      end
      ser_q.push_back(s);
    end
    r.err = 1'b0;
    if (P != 0) begin
      s.mode = MODE_HOLD;
      if (rx) begin
        s.b = 1'b0; s.chk = 1'b0;
        rxbit_q.push_back((^word) ^ pbad);
        r.err = pbad;
      end else begin
        s.b = ^data; s.chk = 1'b1;
      end
      ser_q.push_back(s);
    end
    r.data = rx ? word : '0;
    r.cyc  = e + W + 1 + P;
    rsp_q.push_back(r);
  endtask

  task automatic send(input logic rx, input logic dir, input logic [W-1:0] data,
                      input logic [W-1:0] bits, input logic pbad);
    int n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      check("cmd_ready_timeout", cmd_ready, 1);
    end else begin
      issue(rx, dir, data, bits, pbad);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  // Serial peer: presents the next receive bit whenever the DUT is shifting.
  always @(negedge clk) begin
    if (ser_valid === 1'b1 && rxbit_q.size() != 0) ser_in = rxbit_q.pop_front();
    else                                            ser_in = 1'($urandom_range(0, 1));
  end

  ser_t mon_s;
  rsp_t mon_r;

  always @(negedge clk) begin
    if (mon_en) begin
      if (load_q.size() != 0 && load_q[0] == cyc) begin
        check("load_mode", mode, MODE_LOAD);
        void'(load_q.pop_front());
      end
      if (ser_valid === 1'b1) begin
        if (ser_q.size() == 0) check("ser_valid_unexpected", ser_valid, 0);
        else begin
          mon_s = ser_q.pop_front();
          if (mon_s.chk) check("ser_out", ser_out, mon_s.b);
          check("shift_mode", mode, mon_s.mode);
        end
      end else begin
        check("ser_out_idle", ser_out, 0);
      end
      if (rsp_valid === 1'b1) begin
        if (rsp_q.size() == 0) check("rsp_valid_unexpected", rsp_valid, 0);
        else begin
          mon_r = rsp_q.pop_front();
          check("rsp_cycle", cyc, mon_r.cyc);
          check("rsp_data", rsp_data, mon_r.data);
          check("rsp_err", rsp_err, mon_r.err);
          check("rsp_mode", mode, MODE_HOLD);
        end
      end else begin
        check("rsp_data_idle", rsp_data, 0);
        check("rsp_err_idle", rsp_err, 0);
      end
    end
  end

  initial begin
    int e_prev, accepts, n;

    // Reset for two cycles
    @(negedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_ser_out", ser_out, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_mode", mode, MODE_HOLD);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_mode", mode, MODE_HOLD);

    // Directed transfers
    send(1'b0, 1'b1, 4'b1011, 4'b0000, 1'b0);
    send(1'b0, 1'b0, 4'b1011, 4'b0000, 1'b0);
    send(1'b1, 1'b1, 4'b0000, 4'b0011, 1'b0);
    send(1'b1, 1'b0, 4'b0000, 4'b0011, 1'b0);
    send(1'b1, 1'b1, 4'b0000, 4'b0011, 1'b1);
    send(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    send(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0);

    // cmd_valid held high: accepts only when idle, evenly spaced
    @(negedge clk);
    accepts = 0; e_prev = 0; n = 0;
    cmd_valid = 1'b1;
    while (accepts < 3 && n < 100) begin
      if (cmd_ready === 1'b1) begin
        if (accepts > 0) check("accept_spacing", cyc + 1 - e_prev, W + 3 + P);
        e_prev = cyc + 1;
        issue(1'b0, 1'($urandom_range(0, 1)), W'($urandom), '0, 1'b0);
        accepts++;
      end
      @(negedge clk);
      n++;
    end
    if (accepts < 3) check("stream_accepts", accepts, 3);
    cmd_valid = 1'b0;

    // Reset in the 2nd SHIFT cycle aborts the transfer silently
    send(1'b0, 1'b1, 4'b1010, 4'b0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    ser_q.delete();
    rsp_q.delete();
    load_q.delete();
    rxbit_q.delete();
    @(negedge clk);
    check("abort_cmd_ready", cmd_ready, 0);
    check("abort_ser_valid", ser_valid, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_mode", mode, MODE_HOLD);
    rst = 1'b0;
    send(1'b1, 1'b1, 4'b0000, 4'b0101, 1'b0);

    // Random traffic
    for (int k = 0; k < 30; k++) begin
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom),
           W'($urandom), 1'($urandom_range(0, 1)));
    end

    n = 0;
    while ((rsp_q.size() != 0 || ser_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_rsp", rsp_q.size(), 0);
    check("drain_ser", ser_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
